// File: rtl/counter_369_monitor_pkg.sv
// Shared types, constants and transition table for the 369 count stream.
// Used by the monitor RTL and by the counter-side benches.
package counter_369_monitor_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  localparam logic [3:0] V0  = 4'd0;
  localparam logic [3:0] V3  = 4'd3;
  localparam logic [3:0] V6  = 4'd6;
  localparam logic [3:0] V9  = 4'd9;
  localparam logic [3:0] V13 = 4'd13;

  typedef struct packed {
    logic       legal;
    logic [3:0] nxt;
  } succ_t;

  function automatic succ_t succ_369(input logic [3:0] v);
    succ_t r;
    r.legal = 1'b1;
    r.nxt   = V0;
    case (v)
      V0:      r.nxt = V3;
      V3:      r.nxt = V6;
      V6:      r.nxt = V9;
      V9:      r.nxt = V13;
      V13:     r.nxt = V6;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic legal_369(input logic [3:0] v);
    return v inside {V0, V3, V6, V9, V13};
  endfunction

endpackage

// File: rtl/counter_369_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk)
    cnt_q <= cnt_d;

  assign cnt = cnt_q;

endmodule

// File: rtl/counter_369_monitor.sv
// Receive-side monitor for the 369 count stream: locks onto the
// sequence, flags bad samples, counts locked errors, pulses clap.
import counter_369_monitor_pkg::*;

module counter_369_monitor #(
  parameter int LOCK_LEN = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [3:0]       count,
  output logic             locked,
  output logic [3:0]       expected,
  output logic             clap,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [2:0] LOCK_N = 3'(LOCK_LEN);

  mon_state_t state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic [2:0] match_q, match_d;
  logic       clap_q, clap_d;
  logic       mm_q, mm_d;
  logic       err_inc;

  succ_t      ref_s;
  logic       in_legal;
  logic       in_seq;
  logic [2:0] match_inc;

  always_comb begin
    ref_s     = succ_369(prev_q);
    in_legal  = legal_369(count);
    in_seq    = ref_s.legal && (count == ref_s.nxt);
    match_inc = match_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HUNT;
      prev_q  <= V0;
      match_q <= 3'd0;
      clap_q  <= 1'b0;
      mm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      match_q <= match_d;
      clap_q  <= clap_d;
      mm_q    <= mm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    match_d = match_q;
    clap_d  = 1'b0;
    mm_d    = 1'b0;
    err_inc = 1'b0;
    if (valid) begin
      clap_d = in_legal && (count != V0);
      unique case (state_q)
        HUNT: begin
          if (in_legal) begin
            prev_d  = count;
            match_d = 3'd0;
            state_d = TRACK;
          end else begin
            mm_d = 1'b1;
          end
        end
        TRACK: begin
          unique case (1'b1)
            !in_legal: begin
              mm_d    = 1'b1;
              state_d = HUNT;
            end
            in_seq: begin
              prev_d  = count;
              match_d = match_inc;
              if (match_inc == LOCK_N)
                state_d = LOCKED;
            end
            default: begin
              mm_d    = 1'b1;
              prev_d  = count;
              match_d = 3'd0;
            end
          endcase
        end
        LOCKED: begin
          unique case (1'b1)
            !in_legal: begin
              mm_d    = 1'b1;
              err_inc = 1'b1;
              state_d = HUNT;
            end
            in_seq: begin
              prev_d = count;
            end
            default: begin
              mm_d    = 1'b1;
              err_inc = 1'b1;
              prev_d  = count;
              match_d = 3'd0;
              state_d = TRACK;
            end
          endcase
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    locked   = (state_q == LOCKED);
    expected = (state_q == HUNT) ? V0 : ref_s.nxt;
    clap     = clap_q;
    mismatch = mm_q;
  end

  sat_counter #(
    .WIDTH(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .clear(reset),
    .inc  (err_inc),
    .cnt  (err_cnt)
  );

endmodule
